mem_access_ctrl: RTL

- Sequencer between the multi-cycle CPU control/datapath and the unified instruction/data byte memory.
- The memory has a combinational 16-bit little-endian read port ({byte[a+1], byte[a]}) and an 8-bit synchronous write port.
- This block turns fetch, load and store requests into memory cycles, latches the instruction register (IR) and the memory data register (MDR), and splits 16-bit stores into two byte writes.
- It also rejects accesses that fall outside the memory.

---
 rtl/mem_access_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: turns fetch/load/store requests into cycles on a
// 16-bit combinational read / 8-bit synchronous write byte memory, holding IR and MDR.
module mem_access_ctrl #(
    parameter int          ADDR_W    = 8,
    parameter int          MEM_BYTES = 64,
    parameter logic [15:0] IR_RESET  = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_fetch,
    input  logic              req_load,
    input  logic              req_store,
    input  logic              store_byte,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [15:0]       wdata_in,
    input  logic [15:0]       mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wd,
    output logic              mem_we,
    output logic [15:0]       instr,
    output logic [15:0]       data_out,
    output logic              busy,
    output logic              done,
    output logic              range_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ST_LO,
        S_ST_HI
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr_q;
    logic [15:0]       r_wdata_q;
    logic              r_byte_q;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_instr;
    logic [15:0]       r_data;
    logic              r_done;
    logic              r_err;

    logic [31:0]       w_addr_ext;
    logic              w_word_ok;
    logic              w_byte_ok;
    logic              w_accept;
    logic              w_done_nxt;
    logic              w_err_nxt;

    // Range check is done at 32 bits so addr+1 cannot wrap back into range.
    assign w_addr_ext = 32'(addr_in);
    assign w_word_ok  = (w_addr_ext + 32'd1) < 32'(MEM_BYTES);
    assign w_byte_ok  = w_addr_ext < 32'(MEM_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_fetch) begin
                    if (w_word_ok) begin
                        w_state_nxt = S_FETCH;
                        w_accept    = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end else if (req_load) begin
                    if (w_word_ok) begin
                        w_state_nxt = S_LOAD;
                        w_accept    = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end else if (req_store) begin
                    if (store_byte ? w_byte_ok : w_word_ok) begin
                        w_state_nxt = S_ST_LO;
                        w_accept    = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end
            end
            S_FETCH, S_LOAD: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            S_ST_LO: begin
                if (r_byte_q) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_ST_HI;
                end
            end
            S_ST_HI: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wd = 8'h00;
        busy   = (r_state != S_IDLE);
        case (r_state)
            S_ST_LO: begin
                mem_we = 1'b1;
                mem_wd = r_wdata_q[7:0];
            end
            S_ST_HI: begin
                mem_we = 1'b1;
                mem_wd = r_wdata_q[15:8];
            end
            default: begin
                mem_we = 1'b0;
                mem_wd = 8'h00;
            end
        endcase
    end

    // Request capture; only meaningful after an accept, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr_q  <= addr_in;
            r_wdata_q <= wdata_in;
            r_byte_q  <= store_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr <= '0;
            r_instr    <= IR_RESET;
            r_data     <= 16'h0000;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if (w_accept) begin
                r_mem_addr <= addr_in;
            end else if ((r_state == S_ST_LO) && !r_byte_q) begin
                r_mem_addr <= r_addr_q + 1'b1;
            end
            if (r_state == S_FETCH) begin
                r_instr <= mem_rd;
            end
            if (r_state == S_LOAD) begin
                r_data <= mem_rd;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign instr     = r_instr;
    assign data_out  = r_data;
    assign done      = r_done;
    assign range_err = r_err;

endmodule
